// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding and baud-rate derivation.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50000000;
  localparam int UART_BPS_DEF = 115200;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  localparam int BPS_CNT_DEF = bps_cnt(CLK_FREQ_DEF, UART_BPS_DEF);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry holding register, frame-error pulse
// and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int UART_BPS = UART_BPS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rx_ready,
  input  logic       ovr_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam int          BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [15:0] CNT_MAX  = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_HALF = 16'(BPS_CNT / 2 - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (RX),
    .rx_s  (rx_s)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_prev_q, rx_prev_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        byte_good, byte_bad;

  // Frame FSM: start-bit qualification at half a bit, then full-bit steps to
  // land every later sample mid-bit.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_prev_d = rx_s;
    byte_good = 1'b0;
    byte_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            byte_good = 1'b1;
            state_d   = IDLE;
          end else begin
            byte_bad = 1'b1;
            state_d  = WAIT_HI;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      WAIT_HI: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a same-cycle handshake frees the slot for the new byte;
  // an overrun set takes priority over ovr_clr.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q && !rx_ready;
    rx_done_d   = 1'b0;
    frame_err_d = byte_bad;
    overrun_d   = overrun_q && !ovr_clr;
    if (byte_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        rx_done_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_prev_q   <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_prev_q   <= rx_prev_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level timing model checked every cycle plus literal spot checks.
module tb_uart_rx;

  localparam int BIT = 434;
  // Edge of the stop-bit sample, counted from the edge after which the start bit is driven:
  // 2 sync + 1 edge detect, half bit to qualify start, then 8 data bits and the stop bit.
  localparam int SAMPLE_OFS = 3 + BIT / 2 + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst_n, RX, rx_ready, ovr_clr;
  logic [7:0] rx_data;
  logic       rx_valid, rx_done, frame_err, overrun;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rx_ready  (rx_ready),
    .ovr_clr   (ovr_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         good;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt, valid_cnt, ferr_cnt;
  logic [7:0] last_done_data;
  logic [7:0] m_data;
  bit         m_valid, m_done, m_ferr, m_ovr, m_good, m_bad, m_set;

  // Frame-level model: each frame completes at a known edge; the holding register
  // obeys load / handshake / overrun rules.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_data = 8'h00; m_valid = 0; m_done = 0; m_ferr = 0; m_ovr = 0;
      evq.delete();
    end else begin
      m_good = 0; m_bad = 0; m_set = 0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        m_good = ev.good;
        m_bad  = !ev.good;
      end
      m_done = 0;
      m_ferr = m_bad;
      if (m_good && (!m_valid || rx_ready)) begin
        m_data = ev.data; m_valid = 1; m_done = 1;
      end else begin
        if (m_good) m_set = 1;
        if (m_valid && rx_ready) m_valid = 0;
      end
      if (m_set) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      vectors++;
      if (rx_data !== m_data || rx_valid !== m_valid || rx_done !== m_done ||
          frame_err !== m_ferr || overrun !== m_ovr) begin
        miscompares++;
        $display("FAIL cycle %0d outputs: got data=%h vld=%b done=%b ferr=%b ovr=%b, want data=%h vld=%b done=%b ferr=%b ovr=%b",
                 cyc, rx_data, rx_valid, rx_done, frame_err, overrun,
                 m_data, m_valid, m_done, m_ferr, m_ovr);
      end
      if (rx_done === 1'b1) begin done_cnt++; last_done_data = rx_data; end
      if (rx_valid === 1'b1) valid_cnt++;
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    done_cnt = 0; valid_cnt = 0; ferr_cnt = 0; last_done_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    ev_t e;
    e.cyc = cyc + SAMPLE_OFS; e.data = b; e.good = stop;
    evq.push_back(e);
    RX = 1'b0; step(BIT);
    for (int i = 0; i < 8; i++) begin RX = b[i]; step(BIT); end
    RX = stop; step(BIT);
    RX = 1'b1;
  endtask

  task automatic pulse_at(input int n, input bit which);
    step(n);
    if (which) ovr_clr = 1'b1; else rx_ready = 1'b1;
    step(1);
    if (which) ovr_clr = 1'b0; else rx_ready = 1'b0;
  endtask

  initial begin
    RX = 1'b1; rst_n = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0;
    clr_cnt();
    step(3);
    chk("reset_data", 32'(rx_data), 32'h00);
    chk("reset_flags", {29'd0, rx_valid, overrun, frame_err}, 32'h0);
    rst_n = 1'b1; step(5);

    // 0xA5 with consumer always ready
    rx_ready = 1'b1; clr_cnt();
    send_frame(8'hA5, 1'b1); step(10);
    chk("a5_data", 32'(last_done_data), 32'hA5);
    chk("a5_done_pulses", done_cnt, 1);
    chk("a5_valid_cycles", valid_cnt, 1);
    chk("a5_ferr", ferr_cnt, 0);

    // 100-cycle glitch on the line
    clr_cnt();
    RX = 1'b0; step(100); RX = 1'b1; step(600);
    chk("glitch_activity", done_cnt + ferr_cnt + valid_cnt, 0);

    // bad stop bit, then a clean frame
    rx_ready = 1'b0; clr_cnt();
    send_frame(8'h3C, 1'b0); step(20);
    chk("bad_stop_ferr", ferr_cnt, 1);
    chk("bad_stop_done", done_cnt, 0);
    send_frame(8'h3C, 1'b1); step(10);
    chk("good_3c_data", 32'(rx_data), 32'h3C);
    chk("good_3c_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1; step(1); rx_ready = 1'b0; step(2);

    // overrun with consumer stalled
    send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1); step(10);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_set", 32'(overrun), 1);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0; step(2);
    chk("ovr_cleared", 32'(overrun), 0);

    // handshake on the exact load edge
    clr_cnt();
    fork
      send_frame(8'h22, 1'b1);
      pulse_at(SAMPLE_OFS - 1, 1'b0);
    join
    step(10);
    chk("hs_load_data", 32'(rx_data), 32'h22);
    chk("hs_load_ovr", 32'(overrun), 0);
    chk("hs_load_done", done_cnt, 1);

    // overrun set and ovr_clr on the same edge
    fork
      send_frame(8'h44, 1'b1);
      pulse_at(SAMPLE_OFS - 1, 1'b1);
    join
    step(10);
    chk("set_wins_ovr", 32'(overrun), 1);
    chk("set_wins_data", 32'(rx_data), 32'h22);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0; step(2);

    // reset during bit 4 of 0xFF, then 0x00
    clr_cnt();
    RX = 1'b0; step(BIT);
    for (int i = 0; i < 4; i++) begin RX = 1'b1; step(BIT); end
    step(200);
    rst_n = 1'b0; step(3);
    chk("midrst_state", {rx_data, 5'd0, rx_valid, overrun, frame_err}, 32'h0);
    rst_n = 1'b1;
    step(BIT - 203 + 4 * BIT);
    chk("midrst_quiet", done_cnt + ferr_cnt, 0);
    send_frame(8'h00, 1'b1); step(10);
    chk("post_rst_valid", 32'(rx_valid), 1);
    chk("post_rst_data", 32'(rx_data), 32'h00);
    chk("post_rst_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
